rgmii_rx_decode: RTL and testbench

Receive-side RGMII decoder that sits directly downstream of the generic input DDR register. It takes the per-edge samples of RXD[3:0] and RX_CTL and produces a GMII byte stream with a byte-valid strobe: one byte per clock at 1000 Mb/s, one byte per two clocks at 10/100 Mb/s. It also extracts the RGMII in-band link status carried during inter-frame idle. Output feeds the GMII receive MAC path.

---
 rtl/rgmii_rx_decode_pkg.sv | 8 +
 rtl/rgmii_rx_decode_if.sv | 24 ++
 rtl/rgmii_rx_decode_nibble_pack.sv | 47 ++++
 rtl/rgmii_rx_decode.sv | 89 ++++++++
 tb/tb_rgmii_rx_decode.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_rx_decode_pkg.sv
// rgmii_rx_decode_pkg: shared speed codes and nibble-state encoding
package rgmii_rx_decode_pkg;
  typedef logic [1:0] speed_t;
  localparam speed_t SPEED_10   = 2'b00;
  localparam speed_t SPEED_100  = 2'b01;
  localparam speed_t SPEED_1000 = 2'b10;
  typedef enum logic {EMPTY = 1'b0, LOW = 1'b1} nib_state_t;
endpackage

// File: rtl/rgmii_rx_decode_if.sv
// rgmii_rx_decode_if: DDR-sample inputs, GMII outputs and in-band link status
interface rgmii_rx_decode_if;
  import rgmii_rx_decode_pkg::*;
  logic [3:0] rxd_q1;
  logic [3:0] rxd_q2;
  logic       ctl_q1;
  logic       ctl_q2;
  speed_t     speed;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       gmii_rx_clk_en;
  logic       link_up;
  speed_t     link_speed;
  logic       link_duplex;
  modport master (
    output rxd_q1, rxd_q2, ctl_q1, ctl_q2, speed,
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, link_up, link_speed, link_duplex
  );
  modport slave (
    input  rxd_q1, rxd_q2, ctl_q1, ctl_q2, speed,
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, link_up, link_speed, link_duplex
  );
endinterface

// File: rtl/rgmii_rx_decode_nibble_pack.sv
// rgmii_nibble_pack: pairs 10/100 SDR nibbles into bytes, paces idle strobes at one per two cycles
module rgmii_nibble_pack
  import rgmii_rx_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nibble,
  input  logic       dv,
  input  logic       er,
  input  logic       flush,
  output logic [7:0] out_byte,
  output logic       out_dv,
  output logic       out_er,
  output logic       strobe
);
  nib_state_t state_q, state_d;
  logic [3:0] low_q, low_d;
  logic       low_er_q, low_er_d, phase_q, phase_d;
  // state, pending low nibble and idle phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      low_q    <= '0;
      low_er_q <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      low_er_q <= low_er_d;
      phase_q  <= phase_d;
    end
  end
  // next state: a frame start always captures the low nibble; phase locks to the byte slot
  always_comb begin
    state_d  = flush ? EMPTY : (state_q == EMPTY && dv) ? LOW : EMPTY;
    low_d    = (state_q == EMPTY && dv) ? nibble : low_q;
    low_er_d = (state_q == EMPTY && dv) ? er : low_er_q;
    phase_d  = (state_q == EMPTY && dv) ? 1'b1 : (state_q == LOW) ? 1'b0 : ~phase_q;
  end
  // outputs: full byte, odd-nibble flush byte with error, or paced idle byte
  always_comb begin
    out_byte = (state_q == LOW) ? {dv ? nibble : 4'h0, low_q} : {4'h0, nibble};
    out_dv   = (state_q == LOW);
    out_er   = (state_q == LOW) ? (dv ? (low_er_q | er) : 1'b1) : er;
    strobe   = !flush && ((state_q == LOW) || (!dv && phase_q));
  end
endmodule

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: RGMII DDR samples to GMII byte stream plus in-band link status
module rgmii_rx_decode
  import rgmii_rx_decode_pkg::*;
#(
  parameter bit INBAND_STATUS = 1'b1
) (
  input logic clk,
  input logic rst,
  rgmii_rx_decode_if.slave bus
);
  logic       dv, er_n, gig, flush, idle, match;
  logic [7:0] pk_byte;
  logic       pk_dv, pk_er, pk_strobe;
  speed_t     cur_speed_q, cur_speed_d, link_speed_q, link_speed_d;
  logic [7:0] gmii_rxd_q, gmii_rxd_d;
  logic       gmii_rx_dv_q, gmii_rx_dv_d, gmii_rx_er_q, gmii_rx_er_d;
  logic       gmii_rx_clk_en_q, gmii_rx_clk_en_d;
  logic       link_up_q, link_up_d, link_duplex_q, link_duplex_d;
  logic [3:0] cand_q, cand_d;
  logic       cand_vld_q, cand_vld_d;
  assign dv    = bus.ctl_q1;
  assign er_n  = bus.ctl_q1 ^ bus.ctl_q2;
  assign gig   = cur_speed_q[1];
  assign idle  = !bus.ctl_q1 && !bus.ctl_q2;
  assign flush = gig || (cur_speed_d != cur_speed_q);
  rgmii_nibble_pack u_pack (
    .clk      (clk),
    .rst      (rst),
    .nibble   (bus.rxd_q1),
    .dv       (dv),
    .er       (er_n),
    .flush    (flush),
    .out_byte (pk_byte),
    .out_dv   (pk_dv),
    .out_er   (pk_er),
    .strobe   (pk_strobe)
  );
  // speed only follows the configuration outside frames
  always_comb cur_speed_d = dv ? cur_speed_q : bus.speed;
  // output mux between the DDR byte path and the nibble packer
  always_comb begin
    gmii_rxd_d       = gig ? {bus.rxd_q2, bus.rxd_q1} : pk_byte;
    gmii_rx_dv_d     = gig ? dv : pk_dv && pk_strobe;
    gmii_rx_er_d     = gig ? er_n : pk_er && pk_strobe;
    gmii_rx_clk_en_d = gig || pk_strobe;
  end
  // status filter: accept an idle nibble once two consecutive idle cycles agree
  always_comb begin
    match         = INBAND_STATUS && idle && cand_vld_q && (cand_q == bus.rxd_q1);
    cand_d        = idle ? bus.rxd_q1 : cand_q;
    cand_vld_d    = idle;
    link_up_d     = match ? bus.rxd_q1[0] : link_up_q;
    link_speed_d  = match ? bus.rxd_q1[2:1] : link_speed_q;
    link_duplex_d = match ? bus.rxd_q1[3] : link_duplex_q;
  end
  // all outputs and state registered with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_speed_q      <= SPEED_10;
      gmii_rxd_q       <= '0;
      gmii_rx_dv_q     <= 1'b0;
      gmii_rx_er_q     <= 1'b0;
      gmii_rx_clk_en_q <= 1'b0;
      link_up_q        <= 1'b0;
      link_speed_q     <= SPEED_10;
      link_duplex_q    <= 1'b0;
      cand_q           <= '0;
      cand_vld_q       <= 1'b0;
    end else begin
      cur_speed_q      <= cur_speed_d;
      gmii_rxd_q       <= gmii_rxd_d;
      gmii_rx_dv_q     <= gmii_rx_dv_d;
      gmii_rx_er_q     <= gmii_rx_er_d;
      gmii_rx_clk_en_q <= gmii_rx_clk_en_d;
      link_up_q        <= link_up_d;
      link_speed_q     <= link_speed_d;
      link_duplex_q    <= link_duplex_d;
      cand_q           <= cand_d;
      cand_vld_q       <= cand_vld_d;
    end
  end
  assign bus.gmii_rxd       = gmii_rxd_q;
  assign bus.gmii_rx_dv     = gmii_rx_dv_q;
  assign bus.gmii_rx_er     = gmii_rx_er_q;
  assign bus.gmii_rx_clk_en = gmii_rx_clk_en_q;
  assign bus.link_up        = link_up_q;
  assign bus.link_speed     = link_speed_q;
  assign bus.link_duplex    = link_duplex_q;
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed scenarios with hand-computed GMII and status expectations
module tb_rgmii_rx_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  rgmii_rx_decode_if bus ();
  rgmii_rx_decode_if bus2 ();
  assign bus2.rxd_q1 = bus.rxd_q1;
  assign bus2.rxd_q2 = bus.rxd_q2;
  assign bus2.ctl_q1 = bus.ctl_q1;
  assign bus2.ctl_q2 = bus.ctl_q2;
  assign bus2.speed  = bus.speed;
  rgmii_rx_decode #(.INBAND_STATUS(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  rgmii_rx_decode #(.INBAND_STATUS(1'b0)) dut_nostat (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;

  task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic c1, input logic c2);
    bus.rxd_q1 = a;
    bus.rxd_q2 = b;
    bus.ctl_q1 = c1;
    bus.ctl_q2 = c2;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.speed = 2'b00;
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, bus.link_up, bus.link_speed, bus.link_duplex} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%b/%b/%b/%b/%b/%b required all 0", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, bus.link_up, bus.link_speed, bus.link_duplex);
    end
    rst = 1'b0;
  endtask

  task automatic test_gig_frame();
    logic [7:0] b;
    bus.speed = 2'b10;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 72; i++) begin
      b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i - 7);
      cyc(b[3:0], b[7:4], 1, 1);
      n_checks++;
      if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {b, 3'b101}) begin
        n_fail++;
        $display("FAIL gig_frame[%0d] rxd/dv/er/en got %h/%b/%b/%b required %h/1/0/1", i, bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, b);
      end
    end
    cyc(4'hF, 4'hF, 0, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'hFF, 3'b011}) begin
      n_fail++;
      $display("FAIL gig_carrier_ext got %h/%b/%b/%b required ff/0/1/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
  endtask

  task automatic test_100_frame();
    logic [7:0] b;
    bus.speed = 2'b01;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : (i == 8) ? 8'h01 : 8'h02;
      cyc(b[3:0], b[3:0], 1, 1);
      n_checks++;
      if (bus.gmii_rx_clk_en !== 1'b0) begin
        n_fail++;
        $display("FAIL m100_low_slot[%0d] clk_en got %b required 0", i, bus.gmii_rx_clk_en);
      end
      cyc(b[7:4], b[7:4], 1, 1);
      n_checks++;
      if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {b, 3'b101}) begin
        n_fail++;
        $display("FAIL m100_byte[%0d] rxd/dv/er/en got %h/%b/%b/%b required %h/1/0/1", i, bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, b);
      end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (bus.gmii_rx_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL m100_post_gap clk_en got %b required 0", bus.gmii_rx_clk_en);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({bus.gmii_rx_dv, bus.gmii_rx_clk_en} !== 2'b01) begin
      n_fail++;
      $display("FAIL m100_post_idle dv/en got %b/%b required 0/1", bus.gmii_rx_dv, bus.gmii_rx_clk_en);
    end
  endtask

  task automatic test_odd_nibble();
    cyc(4'hA, 4'hA, 1, 1);
    cyc(4'hB, 4'hB, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'hBA, 3'b101}) begin
      n_fail++;
      $display("FAIL odd_first got %h/%b/%b/%b required ba/1/0/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    cyc(4'hC, 4'hC, 1, 1);
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h0C, 3'b111}) begin
      n_fail++;
      $display("FAIL odd_flush got %h/%b/%b/%b required 0c/1/1/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    cyc(0, 0, 0, 0);
    cyc(4'h7, 4'h7, 0, 0);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h07, 3'b001}) begin
      n_fail++;
      $display("FAIL odd_idle got %h/%b/%b/%b required 07/0/0/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
  endtask

  task automatic test_error();
    bus.speed = 2'b10;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'h1, 4'h1, 1, 1);
    cyc(4'h2, 4'h2, 1, 0);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h22, 3'b111}) begin
      n_fail++;
      $display("FAIL gig_err got %h/%b/%b/%b required 22/1/1/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    cyc(4'h3, 4'h3, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h33, 3'b101}) begin
      n_fail++;
      $display("FAIL gig_after_err got %h/%b/%b/%b required 33/1/0/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    bus.speed = 2'b01;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'h1, 4'h1, 1, 1);
    cyc(4'h2, 4'h2, 1, 0);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h21, 3'b111}) begin
      n_fail++;
      $display("FAIL m100_err_high got %h/%b/%b/%b required 21/1/1/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    cyc(4'h3, 4'h3, 1, 1);
    cyc(4'h4, 4'h4, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h43, 3'b101}) begin
      n_fail++;
      $display("FAIL m100_after_err got %h/%b/%b/%b required 43/1/0/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_inband();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'hD, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b0000) begin
      n_fail++;
      $display("FAIL status_single got %b required 0000", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
    cyc(4'hD, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1101) begin
      n_fail++;
      $display("FAIL status_dd got %b required 1101", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
    n_checks++;
    if ({bus2.link_up, bus2.link_speed, bus2.link_duplex} !== 4'b0000) begin
      n_fail++;
      $display("FAIL status_disabled got %b required 0000", {bus2.link_up, bus2.link_speed, bus2.link_duplex});
    end
    cyc(4'h3, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1101) begin
      n_fail++;
      $display("FAIL status_d3 got %b required 1101", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
    cyc(4'h3, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1010) begin
      n_fail++;
      $display("FAIL status_33 got %b required 1010", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
    cyc(4'h5, 0, 0, 0);
    cyc(4'h5, 0, 0, 1);
    cyc(4'h5, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1010) begin
      n_fail++;
      $display("FAIL status_broken got %b required 1010", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
    cyc(4'h5, 0, 0, 0);
    n_checks++;
    if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1100) begin
      n_fail++;
      $display("FAIL status_55 got %b required 1100", {bus.link_up, bus.link_speed, bus.link_duplex});
    end
  endtask

  task automatic test_reset_mid_frame();
    cyc(4'hA, 4'hA, 1, 1);
    rst = 1'b1;
    cyc(4'hB, 4'hB, 1, 1);
    rst = 1'b0;
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, bus.link_up, bus.link_speed, bus.link_duplex} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_mid_frame got %h/%b/%b/%b/%b/%b/%b required all 0", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en, bus.link_up, bus.link_speed, bus.link_duplex);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_speed_change();
    bus.speed = 2'b01;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'h1, 4'h1, 1, 1);
    bus.speed = 2'b10;
    cyc(4'h2, 4'h2, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_clk_en} !== {8'h21, 1'b1}) begin
      n_fail++;
      $display("FAIL spdchg_old_byte got %h/%b required 21/1", bus.gmii_rxd, bus.gmii_rx_clk_en);
    end
    cyc(4'h3, 4'h3, 1, 1);
    n_checks++;
    if (bus.gmii_rx_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL spdchg_still_nibble clk_en got %b required 0", bus.gmii_rx_clk_en);
    end
    cyc(4'h4, 4'h4, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_clk_en} !== {8'h43, 1'b1}) begin
      n_fail++;
      $display("FAIL spdchg_old_byte2 got %h/%b required 43/1", bus.gmii_rxd, bus.gmii_rx_clk_en);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (bus.gmii_rx_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL spdchg_dv_fall clk_en got %b required 0", bus.gmii_rx_clk_en);
    end
    cyc(4'hA, 4'h9, 1, 1);
    n_checks++;
    if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en} !== {8'h9A, 3'b101}) begin
      n_fail++;
      $display("FAIL spdchg_new_mode got %h/%b/%b/%b required 9a/1/0/1", bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_clk_en);
    end
  endtask

  initial begin
    test_reset();
    test_gig_frame();
    test_100_frame();
    test_odd_nibble();
    test_error();
    test_inband();
    test_reset_mid_frame();
    test_speed_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
